// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-interface emulator on SPI mode 0, oversampled by clk.
// Define ADXL_SPI_SNAPSHOT_EN to freeze axis/temperature inputs per transaction.
module adxl362_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  input  logic [11:0] temp_data,
  output logic [7:0]  power_ctl,
  output logic        measure,
  output logic        txn_done,
  output logic        cmd_err,
  output logic        soft_rst
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, SINK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, ss_sync_q, ss_sync_d;
  logic       sclk_prev_q, ss_prev_q;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d, addr_q, addr_d;
  logic       rd_q, rd_d, miso_q, miso_d, oe_q, oe_d;
  logic       txn_done_q, txn_done_d, cmd_err_q, cmd_err_d, soft_rst_q, soft_rst_d;
  logic [7:0] regs_q [15];
  logic [7:0] regs_d [15];

  logic       sclk_s, mosi_s, ss_s, sclk_rise, sclk_fall, ss_rise, ss_fall, byte_done;
  logic [7:0] byte_in, rd_addr, rdata;
  logic [11:0] xs, ys, zs, ts;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    ss_rise     = ss_s & ~ss_prev_q;
    ss_fall     = ~ss_s & ss_prev_q;
    byte_in     = {rx_q, mosi_s};
    byte_done   = sclk_rise && (bit_cnt_q == 3'd7);
  end

`ifdef ADXL_SPI_SNAPSHOT_EN
  logic [47:0] snap_q, snap_d;
  always_comb snap_d = ss_fall ? {x_data, y_data, z_data, temp_data} : snap_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) snap_q <= '0;
    else        snap_q <= snap_d;
  end
  assign {xs, ys, zs, ts} = snap_q;
`else
  assign {xs, ys, zs, ts} = {x_data, y_data, z_data, temp_data};
`endif

  // The address byte itself is the first read location; later loads use the running pointer.
  always_comb begin
    rd_addr = (state_q == ADDR) ? byte_in : addr_q;
    rdata   = 8'h00;
    case (rd_addr)
      8'h00: rdata = 8'hAD;
      8'h01: rdata = 8'h1D;
      8'h02: rdata = 8'hF2;
      8'h03: rdata = 8'h01;
      8'h08: rdata = xs[11:4];
      8'h09: rdata = ys[11:4];
      8'h0A: rdata = zs[11:4];
      8'h0B: rdata = {7'b0, measure};
      8'h0E: rdata = xs[7:0];
      8'h0F: rdata = {{4{xs[11]}}, xs[11:8]};
      8'h10: rdata = ys[7:0];
      8'h11: rdata = {{4{ys[11]}}, ys[11:8]};
      8'h12: rdata = zs[7:0];
      8'h13: rdata = {{4{zs[11]}}, zs[11:8]};
      8'h14: rdata = ts[7:0];
      8'h15: rdata = {{4{ts[11]}}, ts[11:8]};
      default: if (rd_addr >= 8'h20 && rd_addr <= 8'h2E) rdata = regs_q[rd_addr[3:0]];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    regs_d     = regs_q;
    txn_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    soft_rst_d = 1'b0;
    oe_d       = ~ss_s;
    miso_d     = (state_q == DATA) && rd_q && tx_q[7];

    if (soft_rst_q) begin
      for (int i = 0; i < 15; i++) regs_d[i] = 8'h00;
    end

    // ss high wins over a coincident sclk edge, so a partial byte is never committed.
    if (ss_s) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      txn_done_d = ss_rise;
    end else if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = byte_in[6:0];
      end
      // First fall after a load must keep bit 7 on the line for the next rise.
      if (sclk_fall && state_q == DATA && rd_q && bit_cnt_q != 3'd0)
        tx_d = {tx_q[6:0], 1'b0};
      if (byte_done) begin
        case (state_q)
          CMD: begin
            if (byte_in == 8'h0A || byte_in == 8'h0B) begin
              state_d = ADDR;
              rd_d    = byte_in[0];
            end else begin
              state_d   = SINK;
              cmd_err_d = 1'b1;
            end
          end
          ADDR: begin
            state_d = DATA;
            addr_d  = rd_q ? byte_in + 8'd1 : byte_in;
            if (rd_q) tx_d = rdata;
          end
          DATA: begin
            addr_d = addr_q + 8'd1;
            if (rd_q) begin
              tx_d = rdata;
            end else if (addr_q >= 8'h20 && addr_q <= 8'h2E) begin
              regs_d[addr_q[3:0]] = byte_in;
            end else if (addr_q == 8'h1F && byte_in == 8'h52) begin
              soft_rst_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      txn_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      soft_rst_q  <= 1'b0;
      regs_q      <= '{default: 8'h00};
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      txn_done_q  <= txn_done_d;
      cmd_err_q   <= cmd_err_d;
      soft_rst_q  <= soft_rst_d;
      regs_q      <= regs_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign power_ctl = regs_q[13];
  assign measure   = (regs_q[13][1:0] == 2'b10);
  assign txn_done  = txn_done_q;
  assign cmd_err   = cmd_err_q;
  assign soft_rst  = soft_rst_q;

endmodule

// File: doc/adxl362_spi_responder.md
# adxl362_spi_responder

Synthesizable SPI-mode-0 responder that emulates the ADXL362 accelerometer register interface, so the accelerometer controller and ball-tilt logic can be exercised in simulation and on-board loopback without the physical sensor. It sits where the sensor would be: `sclk`/`mosi`/`ss` come from the SPI master, and `miso` returns to it. Axis and temperature values are supplied on parallel input ports. The block oversamples the SPI lines with the system clock, decodes read and write commands, auto-increments the address, and serves a small register map.

## Interface
- `SYNC_STAGES`, default 2 — synchronizer depth on `sclk`/`mosi`/`ss`; legal range 2–3.
- `clk` in 1 — 100 MHz system clock.
- `reset` in 1 — asynchronous, active-low reset.
- `sclk` in 1 — SPI clock from master; idle low.
- `mosi` in 1 — SPI data from master.
- `ss` in 1 — SPI select, active low.
- `miso` out 1 — SPI data to master.
- `miso_oe` out 1 — high while the responder drives `miso`; the top level tristates on low.
- `x_data`, `y_data`, `z_data` in 12 each — signed axis samples.
- `temp_data` in 12 — signed temperature sample.
- `power_ctl` out 8 — current POWER_CTL (0x2D) contents.
- `measure` out 1 — `power_ctl[1:0]==2'b10`.
- `txn_done` out 1 — one-cycle pulse when a transaction ends (`ss` rising edge detected).
- `cmd_err` out 1 — one-cycle pulse when an unknown command byte completes.
- `soft_rst` out 1 — one-cycle pulse when 0x52 is written to 0x1F.

## Operation
- **Input conditioning:** `sclk`, `mosi` and `ss` each pass through `SYNC_STAGES` flops. Rise/fall edges are detected on the synchronized `sclk` and `ss`.
- **States:**
  - IDLE: entered on reset or `ss` high.
  - CMD: `ss` falling edge; clear bit counter.
  - ADDR: after 8 rising edges in CMD.
  - DATA: after 8 rising edges in ADDR.
  - SINK: unknown command; absorbs all bits until `ss` rises.
  - Any state goes to IDLE on `ss` high.
- **Bit handling:**
  - Bits shift in MSB-first on each synchronized `sclk` rising edge.
  - Commands: 0x0A = write, 0x0B = read. Any other value pulses `cmd_err` and goes to SINK.
- **Read:**
  - At the 8th rising edge of ADDR, and at every 8th rising edge in DATA, load the tx shifter with reg[addr] and post-increment addr.
  - `miso` = tx[7], and the shifter shifts left on each `sclk` falling edge.
  - `miso` = 0 in CMD/ADDR/SINK.
- **Write:** at each 8th rising edge in DATA, commit the byte to reg[addr] if addr is writable, then post-increment addr. Writes to read-only or unmapped addresses are dropped silently.
- **Address:** 8-bit, wraps 0xFF→0x00.
- **Register map:**
  - Read-only:
    - 0x00 = 0xAD, 0x01 = 0x1D, 0x02 = 0xF2, 0x03 = 0x01.
    - 0x08/0x09/0x0A = x/y/z[11:4].
    - 0x0B STATUS = {7'b0, `measure`}.
    - 0x0E–0x15 = X_L, X_H, Y_L, Y_H, Z_L, Z_H, T_L, T_H. Each _L is v[7:0]; each _H is {4{v[11]}, v[11:8]}.
  - Writable, read-back: 0x20–0x2E, reset 0x00.
  - Write-only: 0x1F; reads as 0x00.
  - All other addresses read as 0x00.
- **Soft reset:** a write of 0x52 to 0x1F pulses `soft_rst` and clears 0x20–0x2E one cycle later. Any other value written to 0x1F has no effect.
- **Abort:** `ss` rising mid-byte discards the partial byte. No write occurs. `txn_done` still pulses.
- **Async reset:** an asserted `reset` at any point, including mid-transaction, returns all state to reset values immediately.

## Timing
- **Reset values:**
  - `miso`, `miso_oe`, `txn_done`, `cmd_err`, `soft_rst`, `measure` = 0.
  - `power_ctl` = 0x00.
  - State = IDLE.
- **Supported SCLK:** ≤ `clk`/8. Each SCLK high and low phase must be ≥ 4 `clk`.
- **Edge latency:** from a pin edge to internal action is `SYNC_STAGES`+1 `clk`.
- **MISO timing:** `miso` updates `SYNC_STAGES`+2 `clk` after the `sclk` pin falls.
- **`miso_oe`:** asserts `SYNC_STAGES`+1 `clk` after `ss` falls. Deasserts the same delay after `ss` rises.
- **Outputs and pulses:**
  - `power_ctl` and `measure` update the cycle after the commit.
  - `cmd_err` fires on the cycle the 8th command bit is sampled.
  - `txn_done` fires on the cycle the `ss` rise is detected.
- **Simultaneous events:** an `ss` rise and an `sclk` rise detected in the same cycle resolve to `ss` first, so the bit is dropped.

## Configuration
- **`ADXL_SPI_SNAPSHOT_EN` defined:** `x_data`/`y_data`/`z_data`/`temp_data` are captured into a 48-bit snapshot on the `ss` falling edge, and all reads within that transaction return the snapshot (coherent burst).
- **Not defined:** reads sample the live inputs at each tx-shifter load.

## Test plan
- **Identity burst:** read cmd 0x0B, addr 0x00, 4 bytes → MISO returns 0xAD, 0x1D, 0xF2, 0x01; `txn_done` pulses once.
- **Write/readback:** write 0x0A, addr 0x2D, data 0x02 → `power_ctl`=0x02, `measure`=1; read 0x2D returns 0x02.
- **Axis data:** `x_data`=12'hF85; burst from 0x0E → 0x85, 0xFF. With the snapshot macro on, changing `x_data` mid-burst leaves the bytes unchanged.
- **Error and abort:**
  - cmd 0x55 → `cmd_err` pulse, MISO held 0.
  - Write to 0x20 aborted after 5 data bits → 0x20 remains 0x00.
- **Soft reset:** write 0x52 to 0x1F after 0x2D=0x02 → `soft_rst` pulse, `power_ctl`=0x00.
- **Wrap and mid-transfer reset:**
  - Read from 0xFF for 2 bytes → 0x00, 0xAD.
  - Assert `reset` mid-burst → all outputs 0 on the same cycle.
